// File: rtl/ifetch_unit.sv
// ============================================================================
// Module   : ifetch_unit
// Purpose  : Multi-cycle instruction fetch stage. Holds the PC, fetches one
//            instruction over a req/ack handshake, holds it for the decoder,
//            then computes the next PC from the decoder's control-flow fields.
// Option   : IFETCH_ALIGN_TRAP_EN - trap on a misaligned next PC (HALT state
//            plus sticky misaligned flag) instead of silently clearing [1:0].
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ifetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        resetN,
   input  logic [1:0]  pcSrcCtrl,
   input  logic [25:0] jAddr,
   input  logic [31:0] imm,
   input  logic        brCond,
   input  logic [31:0] regA,
   input  logic        stall,
   output logic [31:0] imAddr,
   output logic        imReq,
   input  logic        imAck,
   input  logic [31:0] imData,
   output logic [31:0] instr,
   output logic        instrValid,
`ifdef IFETCH_ALIGN_TRAP_EN
   output logic        misaligned,
`endif
   output logic [31:0] pc,
   output logic [31:0] pcPlus4
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
`ifdef IFETCH_ALIGN_TRAP_EN
      ST_HALT  = 2'd3,
`endif
      ST_HOLD  = 2'd2
   } state_t;

   state_t      state;
   state_t      state_next;
   logic        capture;
   logic        retire;
   logic [31:0] branch_target;
   logic [31:0] raw_next;
   logic [31:0] next_pc;
`ifdef IFETCH_ALIGN_TRAP_EN
   logic        trap;
   logic        addr_fault;
`endif

   // Outputs depend only on registers and state: no ack/stall feed-through.
   assign imReq   = (state == ST_FETCH);
   assign imAddr  = pc;
   assign pcPlus4 = pc + 32'd4;

   // Next-PC selection; all arithmetic wraps modulo 2^32.
   always_comb begin
      branch_target = pcPlus4 + (imm << 2);
      case (pcSrcCtrl)
         2'b00:   raw_next = pcPlus4;
         2'b01:   raw_next = {pcPlus4[31:28], jAddr, 2'b00};
         2'b10:   raw_next = brCond ? branch_target : pcPlus4;
         default: raw_next = regA;
      endcase
`ifdef IFETCH_ALIGN_TRAP_EN
      next_pc    = raw_next;
      addr_fault = |raw_next[1:0];
`else
      // Only the jump-register path can produce low bits; drop them.
      next_pc    = raw_next & ~32'h3;
`endif
   end

   // State register; reset abandons any outstanding request at once.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) state <= ST_IDLE;
      else         state <= state_next;
   end

   // Next-state logic and datapath strobes.
   always_comb begin
      state_next = state;
      capture    = 1'b0;
      retire     = 1'b0;
`ifdef IFETCH_ALIGN_TRAP_EN
      trap       = 1'b0;
`endif
      case (state)
         ST_IDLE:  state_next = ST_FETCH;
         ST_FETCH: begin
            if (imAck) begin
               capture    = 1'b1;
               state_next = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (!stall) begin
`ifdef IFETCH_ALIGN_TRAP_EN
               if (addr_fault) begin
                  trap       = 1'b1;
                  state_next = ST_HALT;
               end else begin
                  retire     = 1'b1;
                  state_next = ST_FETCH;
               end
`else
               retire     = 1'b1;
               state_next = ST_FETCH;
`endif
            end
         end
`ifdef IFETCH_ALIGN_TRAP_EN
         ST_HALT:  state_next = ST_HALT;
`endif
         default:  state_next = ST_IDLE;
      endcase
   end

   // PC, held instruction and fault flag.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         pc         <= RESET_PC;
         instr      <= 32'd0;
         instrValid <= 1'b0;
`ifdef IFETCH_ALIGN_TRAP_EN
         misaligned <= 1'b0;
`endif
      end else begin
         if (capture) begin
            instr      <= imData;
            instrValid <= 1'b1;
         end
         if (retire) begin
            pc         <= next_pc;
            instrValid <= 1'b0;
         end
`ifdef IFETCH_ALIGN_TRAP_EN
         if (trap) begin
            misaligned <= 1'b1;
            instrValid <= 1'b0;
         end
`endif
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_ifetch_unit.sv
// ============================================================================
// Module   : tb_ifetch_unit
// Purpose  : Self-checking bench for ifetch_unit with an instruction-word
//            scoreboard. Honours IFETCH_ALIGN_TRAP_EN when defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ifetch_unit;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        resetN = 1'b0;
   logic [1:0]  pcSrcCtrl = 2'b00;
   logic [25:0] jAddr = 26'd0;
   logic [31:0] imm = 32'd0;
   logic        brCond = 1'b0;
   logic [31:0] regA = 32'd0;
   logic        stall = 1'b0;
   logic [31:0] imAddr;
   logic        imReq;
   logic        imAck = 1'b0;
   logic [31:0] imData = 32'd0;
   logic [31:0] instr;
   logic        instrValid;
   logic [31:0] pc;
   logic [31:0] pcPlus4;
`ifdef IFETCH_ALIGN_TRAP_EN
   logic        misaligned;
`endif

   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_pc = RESET_PC;
   logic [31:0] exp_q[$];

   ifetch_unit #(.RESET_PC(RESET_PC)) dut (
      .clk        (clk),
      .resetN     (resetN),
      .pcSrcCtrl  (pcSrcCtrl),
      .jAddr      (jAddr),
      .imm        (imm),
      .brCond     (brCond),
      .regA       (regA),
      .stall      (stall),
      .imAddr     (imAddr),
      .imReq      (imReq),
      .imAck      (imAck),
      .imData     (imData),
      .instr      (instr),
      .instrValid (instrValid),
`ifdef IFETCH_ALIGN_TRAP_EN
      .misaligned (misaligned),
`endif
      .pc         (pc),
      .pcPlus4    (pcPlus4)
   );

   always #5 clk = ~clk;

   // Instruction memory contents as a function of address.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One full instruction: fetch with wait_n wait cycles, hold stall_n
   // cycles, then retire with the given control flow and expected next PC.
   task automatic do_instr(input string name, input int wait_n, input int stall_n,
                           input logic [1:0] sel, input logic [25:0] j,
                           input logic [31:0] im, input logic br,
                           input logic [31:0] ra, input logic [31:0] exp_next,
                           input bit exp_trap);
      int          guard;
      logic [31:0] want;
      guard = 0;
      while (imReq !== 1'b1 && guard < 20) begin
         tick();
         guard++;
      end
      checks++;
      if (imReq !== 1'b1) begin
         errors++;
         $display("FAIL %s req_timeout: imReq=%b required 1", name, imReq);
         return;
      end
      checks++;
      if (imAddr !== exp_pc) begin
         errors++;
         $display("FAIL %s req_addr: imAddr=%h required %h", name, imAddr, exp_pc);
      end
      for (int i = 0; i < wait_n; i++) begin
         imAck  = 1'b0;
         imData = $urandom;
         tick();
         checks++;
         if (imReq !== 1'b1 || imAddr !== exp_pc || instrValid !== 1'b0) begin
            errors++;
            $display("FAIL %s wait_hold: imReq=%b imAddr=%h instrValid=%b required 1 %h 0",
                     name, imReq, imAddr, instrValid, exp_pc);
         end
      end
      imAck  = 1'b1;
      imData = mem_word(exp_pc);
      exp_q.push_back(mem_word(exp_pc));
      tick();
      imAck  = 1'b0;
      imData = $urandom;
      checks++;
      if (instrValid !== 1'b1 || imReq !== 1'b0) begin
         errors++;
         $display("FAIL %s capture: instrValid=%b imReq=%b required 1 0", name, instrValid, imReq);
      end
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL %s scoreboard_empty: queue size 0 required >0", name);
         want = 32'd0;
      end else begin
         want = exp_q.pop_front();
         if (instr !== want) begin
            errors++;
            $display("FAIL %s instr: instr=%h required %h", name, instr, want);
         end
      end
      pcSrcCtrl = sel;
      jAddr     = j;
      imm       = im;
      brCond    = br;
      regA      = ra;
      stall     = 1'b1;
      for (int i = 0; i < stall_n; i++) begin
         tick();
         checks++;
         if (instr !== want || instrValid !== 1'b1 || pc !== exp_pc || imReq !== 1'b0) begin
            errors++;
            $display("FAIL %s stall_hold: instr=%h valid=%b pc=%h req=%b required %h 1 %h 0",
                     name, instr, instrValid, pc, imReq, want, exp_pc);
         end
      end
      stall = 1'b0;
      tick();
      if (!exp_trap) begin
         checks++;
         if (pc !== exp_next) begin
            errors++;
            $display("FAIL %s next_pc: pc=%h required %h", name, pc, exp_next);
         end
         checks++;
         if (instrValid !== 1'b0 || imReq !== 1'b1) begin
            errors++;
            $display("FAIL %s retire: instrValid=%b imReq=%b required 0 1", name, instrValid, imReq);
         end
         exp_pc = exp_next;
      end else begin
`ifdef IFETCH_ALIGN_TRAP_EN
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (misaligned !== 1'b1 || pc !== exp_pc || imReq !== 1'b0 || instrValid !== 1'b0) begin
               errors++;
               $display("FAIL %s halt: misaligned=%b pc=%h req=%b valid=%b required 1 %h 0 0",
                        name, misaligned, pc, imReq, instrValid, exp_pc);
            end
            tick();
         end
`else
         checks++;
         errors++;
         $display("FAIL %s trap_unsupported: trap build=0 required 1", name);
`endif
      end
   endtask

   task automatic apply_reset();
      resetN = 1'b0;
      tick();
      tick();
      resetN = 1'b1;
      exp_pc = RESET_PC;
      exp_q.delete();
   endtask

   task automatic test_reset();
      resetN = 1'b0;
      tick();
      tick();
      checks++;
      if (pc !== RESET_PC || imReq !== 1'b0 || instrValid !== 1'b0 || instr !== 32'd0) begin
         errors++;
         $display("FAIL reset_values: pc=%h req=%b valid=%b instr=%h required %h 0 0 0",
                  pc, imReq, instrValid, instr, RESET_PC);
      end
`ifdef IFETCH_ALIGN_TRAP_EN
      checks++;
      if (misaligned !== 1'b0) begin
         errors++;
         $display("FAIL reset_misaligned: misaligned=%b required 0", misaligned);
      end
`endif
      resetN = 1'b1;
      exp_pc = RESET_PC;
      #1;
      checks++;
      if (imReq !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle_req: imReq=%b required 0", imReq);
      end
      tick();
      checks++;
      if (imReq !== 1'b1 || imAddr !== RESET_PC) begin
         errors++;
         $display("FAIL first_req: imReq=%b imAddr=%h required 1 %h", imReq, imAddr, RESET_PC);
      end
   endtask

   task automatic test_zero_wait();
      do_instr("zero_wait", 0, 0, 2'b00, 26'd0, 32'd0, 1'b0, 32'd0, 32'h0000_0004, 1'b0);
   endtask

   task automatic test_delayed_ack();
      do_instr("delay3", 3, 0, 2'b00, 26'd0, 32'd0, 1'b0, 32'd0, 32'h0000_0008, 1'b0);
   endtask

   task automatic test_stall();
      do_instr("stall4", 0, 4, 2'b00, 26'd0, 32'd0, 1'b0, 32'd0, 32'h0000_000C, 1'b0);
   endtask

   task automatic test_control_flow();
      do_instr("goto_1000", 1, 0, 2'b01, 26'h400, 32'd0, 1'b0, 32'd0, 32'h0000_1000, 1'b0);
      do_instr("jump", 0, 0, 2'b01, 26'h40, 32'd0, 1'b0, 32'd0, 32'h0000_0100, 1'b0);
      do_instr("back_1000", 0, 1, 2'b01, 26'h400, 32'd0, 1'b0, 32'd0, 32'h0000_1000, 1'b0);
      do_instr("br_taken", 2, 0, 2'b10, 26'd0, 32'hFFFF_FFFF, 1'b1, 32'd0, 32'h0000_1000, 1'b0);
      do_instr("br_not_taken", 0, 0, 2'b10, 26'd0, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'h0000_1004, 1'b0);
      do_instr("back_1000b", 0, 0, 2'b01, 26'h400, 32'd0, 1'b0, 32'd0, 32'h0000_1000, 1'b0);
      do_instr("jr", 0, 2, 2'b11, 26'h3FF_FFFF, 32'd5, 1'b1, 32'h0000_2000, 32'h0000_2000, 1'b0);
   endtask

   task automatic test_wrap();
      do_instr("jr_top", 0, 0, 2'b11, 26'd0, 32'd0, 1'b0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b0);
      do_instr("seq_wrap", 1, 0, 2'b00, 26'd0, 32'd0, 1'b0, 32'd0, 32'h0000_0000, 1'b0);
      do_instr("br_back_wrap", 0, 0, 2'b10, 26'd0, 32'hFFFF_FFFE, 1'b1, 32'd0, 32'hFFFF_FFFC, 1'b0);
      do_instr("seq_wrap2", 0, 0, 2'b00, 26'd0, 32'd0, 1'b0, 32'd0, 32'h0000_0000, 1'b0);
   endtask

   task automatic test_back_to_back();
      logic [31:0] nxt;
      for (int k = 0; k < 6; k++) begin
         nxt = exp_pc + 32'd4;
         do_instr("b2b", int'($urandom_range(0, 2)), int'($urandom_range(0, 1)),
                  2'b00, 26'd0, 32'd0, 1'b0, 32'd0, nxt, 1'b0);
      end
   endtask

   task automatic test_misaligned();
      do_instr("to_2000", 0, 0, 2'b11, 26'd0, 32'd0, 1'b0, 32'h0000_2000, 32'h0000_2000, 1'b0);
`ifdef IFETCH_ALIGN_TRAP_EN
      do_instr("jr_misaligned", 0, 0, 2'b11, 26'd0, 32'd0, 1'b0, 32'h0000_2002, 32'h0000_2000, 1'b1);
`else
      do_instr("jr_misaligned", 0, 0, 2'b11, 26'd0, 32'd0, 1'b0, 32'h0000_2002, 32'h0000_2000, 1'b0);
`endif
   endtask

   task automatic test_reset_mid_fetch();
      apply_reset();
      tick();
      checks++;
      if (imReq !== 1'b1) begin
         errors++;
         $display("FAIL mid_fetch_pre: imReq=%b required 1", imReq);
      end
      #3;
      resetN = 1'b0;
      #1;
      checks++;
      if (imReq !== 1'b0 || pc !== RESET_PC) begin
         errors++;
         $display("FAIL async_drop: imReq=%b pc=%h required 0 %h", imReq, pc, RESET_PC);
      end
      tick();
      tick();
      imAck  = 1'b1;
      imData = 32'hDEAD_BEEF;
      resetN = 1'b1;
      tick();
      imAck  = 1'b0;
      checks++;
      if (instrValid !== 1'b0 || imReq !== 1'b1 || instr !== 32'd0) begin
         errors++;
         $display("FAIL late_ack_ignored: valid=%b req=%b instr=%h required 0 1 00000000",
                  instrValid, imReq, instr);
      end
      exp_pc = RESET_PC;
      do_instr("recover", 0, 0, 2'b00, 26'd0, 32'd0, 1'b0, 32'd0, 32'h0000_0004, 1'b0);
   endtask

   initial begin
      test_reset();
      test_zero_wait();
      test_delayed_ack();
      test_stall();
      test_control_flow();
      test_wrap();
      test_back_to_back();
      test_misaligned();
      test_reset_mid_fetch();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached required finish");
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire
